// File: rtl/err_pkg.sv
// Shared types, default sizing and weight helper for the weighted IR error path.
package err_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int DATA_W_DEF = 12;
    localparam int ERR_W_DEF  = 16;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    // Channel pair k (2k, 2k+1) carries weight 2^k.
    function automatic int weight_shift(input int ch);
        return ch / 2;
    endfunction

endpackage

// File: rtl/err_sat.sv
// Combinational saturation of a signed value into a narrower signed range.
module err_sat #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    generate
        if (IN_W > OUT_W) begin : g_clip
            localparam int HI_W = IN_W - OUT_W + 1;

            logic [HI_W-1:0] hi;
            logic            fits;

            // In range when all bits above the output sign bit match it.
            always_comb begin
                hi   = din[IN_W-1:OUT_W-1];
                fits = (hi == '0) || (hi == '1);
                if (fits) begin
                    dout = din[OUT_W-1:0];
                end else if (din[IN_W-1]) begin
                    dout = {1'b1, {(OUT_W-1){1'b0}}};
                end else begin
                    dout = {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_ext
            assign dout = OUT_W'(din);
        end
    endgenerate

endmodule

// File: rtl/err_accum_seq.sv
// Sequences NUM_CH IR samples into a signed pair-weighted error,
// saturates it and publishes it with a one-cycle valid pulse.
module err_accum_seq
    import err_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      IR_vld,
    input  logic                      smp_vld,
    input  logic [DATA_W-1:0]         ir_data,
    output logic [$clog2(NUM_CH)-1:0] sel,
    output logic                      busy,
    output logic signed [ERR_W-1:0]   err,
    output logic                      err_vld
);

    localparam int CNT_W = $clog2(NUM_CH);
    localparam int ACC_W = DATA_W + NUM_CH / 2 + 1;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-1:0]        mag;
    logic signed [ACC_W-1:0] sum;
    logic signed [ERR_W-1:0] sat_q;

    logic cnt_last;
    logic clr;
    logic add;
    logic fin;

    assign cnt_last = (cnt == CNT_W'(NUM_CH - 1));

    // Even channels add, odd channels subtract, shift by pair index.
    always_comb begin
        mag = ACC_W'(ir_data) << weight_shift(int'(cnt));
        if (cnt[0]) begin
            sum = acc - $signed(mag);
        end else begin
            sum = acc + $signed(mag);
        end
    end

    err_sat #(
        .IN_W  (ACC_W),
        .OUT_W (ERR_W)
    ) u_sat (
        .din  (sum),
        .dout (sat_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IR_vld wins over smp_vld, including on the last channel.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        add       = 1'b0;
        fin       = 1'b0;
        unique case (state)
            IDLE: begin
                if (IR_vld) begin
                    state_nxt = ACCUM;
                    clr       = 1'b1;
                end
            end
            ACCUM: begin
                if (IR_vld) begin
                    clr = 1'b1;
                end else if (smp_vld) begin
                    add = 1'b1;
                    if (cnt_last) begin
                        fin       = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            err     <= '0;
            err_vld <= 1'b0;
        end else begin
            err_vld <= fin;
            if (clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (fin) begin
                cnt <= '0;
                acc <= '0;
                err <= sat_q;
            end else if (add) begin
                cnt <= cnt + CNT_W'(1);
                acc <= sum;
            end
        end
    end

    assign sel  = cnt;
    assign busy = (state == ACCUM);

endmodule

// File: tb/tb_err_accum_seq.sv
// Directed bench: vector table of full passes plus stall/restart/reset cases.
module tb_err_accum_seq;

    logic               clk;
    logic               rst_n;
    logic               IR_vld;
    logic               smp_vld;
    logic [11:0]        ir_data;
    logic [2:0]         sel;
    logic               busy;
    logic signed [15:0] err;
    logic               err_vld;

    int n_chk;
    int n_err;
    int exp_err_q;

    typedef struct {
        logic [7:0][11:0] d;
        int               exp;
        string            nm;
    } vec_t;

    vec_t tbl[8];

    err_accum_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .IR_vld  (IR_vld),
        .smp_vld (smp_vld),
        .ir_data (ir_data),
        .sel     (sel),
        .busy    (busy),
        .err     (err),
        .err_vld (err_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle_out(input string nm, input int e);
        chk({nm, " err_vld"}, int'(err_vld), 0);
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " sel"}, int'(sel), 0);
        chk({nm, " err"}, int'(err), e);
    endtask

    // Runs one pass; with do_start=0 the DUT must already be in ACCUM at ch0.
    task automatic run_pass(
        input logic [7:0][11:0] d,
        input int               exp,
        input bit               do_start,
        input int               stall_ch,
        input int               stall_n,
        input string            nm
    );
        if (do_start) begin
            @(negedge clk);
            IR_vld  = 1'b1;
            smp_vld = 1'b1;
            ir_data = 12'hFFF;
            @(negedge clk);
            IR_vld = 1'b0;
        end
        for (int ch = 0; ch < 8; ch++) begin
            if (ch == stall_ch) begin
                for (int s = 0; s < stall_n; s++) begin
                    smp_vld = 1'b0;
                    ir_data = 12'hABC;
                    chk({nm, " stall sel"}, int'(sel), ch);
                    chk({nm, " stall err_vld"}, int'(err_vld), 0);
                    chk({nm, " stall err"}, int'(err), exp_err_q);
                    @(negedge clk);
                end
            end
            smp_vld = 1'b1;
            ir_data = d[ch];
            chk({nm, " sel"}, int'(sel), ch);
            chk({nm, " busy"}, int'(busy), 1);
            chk({nm, " err_vld early"}, int'(err_vld), 0);
            @(negedge clk);
        end
        smp_vld = 1'b0;
        chk({nm, " err_vld"}, int'(err_vld), 1);
        chk({nm, " err"}, int'(err), exp);
        chk({nm, " done busy"}, int'(busy), 0);
        chk({nm, " done sel"}, int'(sel), 0);
        exp_err_q = exp;
        @(negedge clk);
        chk({nm, " pulse width"}, int'(err_vld), 0);
        chk({nm, " err hold"}, int'(err), exp);
    endtask

    initial begin
        logic [7:0][11:0] v;

        n_chk     = 0;
        n_err     = 0;
        exp_err_q = 0;
        rst_n     = 1'b0;
        IR_vld    = 1'b0;
        smp_vld   = 1'b0;
        ir_data   = '0;

        for (int i = 0; i < 8; i++) tbl[i].d = '0;
        tbl[0].exp = 0;      tbl[0].nm = "zeros";
        tbl[1].d[0] = 12'd100;
        tbl[1].exp = 100;    tbl[1].nm = "ch0_100";
        tbl[2].d[7] = 12'd100;
        tbl[2].exp = -800;   tbl[2].nm = "ch7_100";
        tbl[3].d[6] = 12'hFFF; tbl[3].d[4] = 12'hFFF;
        tbl[3].exp = 32767;  tbl[3].nm = "sat_pos";
        tbl[4].d[7] = 12'hFFF; tbl[4].d[5] = 12'hFFF;
        tbl[4].exp = -32768; tbl[4].nm = "sat_neg";
        for (int i = 0; i < 8; i++) tbl[5].d[i] = 12'(i + 1);
        tbl[5].exp = -15;    tbl[5].nm = "ramp";
        for (int i = 0; i < 8; i++) tbl[6].d[i] = 12'hFFF;
        tbl[6].exp = 0;      tbl[6].nm = "all_max";
        tbl[7].d[2] = 12'hFFF;
        tbl[7].exp = 8190;   tbl[7].nm = "ch2_max";

        #12;
        chk_idle_out("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_pass(tbl[i].d, tbl[i].exp, 1'b1, -1, 0, tbl[i].nm);
        end

        // Coincident IR_vld on the final channel restarts, err holds.
        @(negedge clk);
        IR_vld = 1'b1;
        @(negedge clk);
        IR_vld = 1'b0;
        for (int ch = 0; ch < 7; ch++) begin
            smp_vld = 1'b1;
            ir_data = 12'hFFF;
            @(negedge clk);
        end
        chk("coinc pre sel", int'(sel), 7);
        IR_vld  = 1'b1;
        smp_vld = 1'b1;
        @(negedge clk);
        IR_vld  = 1'b0;
        smp_vld = 1'b0;
        chk("coinc err_vld", int'(err_vld), 0);
        chk("coinc err", int'(err), exp_err_q);
        chk("coinc busy", int'(busy), 1);
        chk("coinc sel", int'(sel), 0);
        run_pass(tbl[1].d, 100, 1'b0, -1, 0, "coinc_new");

        // Stall at ch3 for 3 cycles.
        run_pass(tbl[5].d, -15, 1'b1, 3, 3, "stall");

        // Restart at ch5 with smp_vld also high.
        @(negedge clk);
        IR_vld = 1'b1;
        @(negedge clk);
        IR_vld = 1'b0;
        for (int ch = 0; ch < 5; ch++) begin
            smp_vld = 1'b1;
            ir_data = 12'd1000;
            @(negedge clk);
        end
        chk("restart pre sel", int'(sel), 5);
        IR_vld  = 1'b1;
        smp_vld = 1'b1;
        ir_data = 12'hFFF;
        @(negedge clk);
        IR_vld = 1'b0;
        chk("restart err_vld", int'(err_vld), 0);
        chk("restart sel", int'(sel), 0);
        chk("restart busy", int'(busy), 1);
        run_pass(tbl[2].d, -800, 1'b0, -1, 0, "restart_new");

        // Reset at ch4, mid-pass.
        @(negedge clk);
        IR_vld = 1'b1;
        @(negedge clk);
        IR_vld = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            smp_vld = 1'b1;
            ir_data = 12'hFFF;
            @(negedge clk);
        end
        chk("rst pre sel", int'(sel), 4);
        rst_n = 1'b0;
        #1;
        exp_err_q = 0;
        chk_idle_out("rst async", 0);
        @(negedge clk);
        rst_n   = 1'b1;
        smp_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle_out("rst idle", 0);
        end
        smp_vld = 1'b0;
        v = '0;
        v[6] = 12'hFFF;
        run_pass(v, 32760, 1'b1, -1, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
